// File: rtl/core_pkg.sv
// Shared core definitions: condition codes, ALU op encodings, flag-write bit
// positions, register-address width and the E-stage control bundle.
package core_pkg;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam int         REGW    = 4;

  // Bit positions inside the 2-bit FlagWrite field
  localparam int FW_NZ = 1;
  localparam int FW_CV = 0;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_ORR = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       memto_reg;
    logic       branch;
    logic       alu_src;
    logic [1:0] alu_ctrl;
    logic [1:0] flag_write;
  } ctrl_t;

endpackage

// File: rtl/id_ex_reg_if.sv
// Decode->Execute boundary bundle: D-stage fields and hazard controls in,
// E-stage fields and the bubble counter out.
interface id_ex_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  import core_pkg::*;

  // ValidD qualifies the D fields; StallE holds E, FlushE loads a bubble and
  // wins over StallE. ValidE qualifies the E fields one cycle later.
  logic             StallE, FlushE, ValidD;
  logic             RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD;
  logic [1:0]       ALUControlD, FlagWriteD;
  logic [3:0]       CondD, FlagsD;
  logic [REGW-1:0]  RA1D, RA2D, WA3D;
  logic [WIDTH-1:0] RD1D, RD2D, ExtImmD;

  logic             ValidE;
  logic             RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE;
  logic [1:0]       ALUControlE, FlagWriteE;
  logic [3:0]       CondE, FlagsE;
  logic [REGW-1:0]  RA1E, RA2E, WA3E;
  logic [WIDTH-1:0] RD1E, RD2E, ExtImmE;
  logic [CNTW-1:0]  BubbleCnt;

  modport master (
    output StallE, FlushE, ValidD,
    output RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD,
    output ALUControlD, FlagWriteD, CondD, FlagsD,
    output RA1D, RA2D, WA3D, RD1D, RD2D, ExtImmD,
    input  ValidE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE,
    input  ALUControlE, FlagWriteE, CondE, FlagsE,
    input  RA1E, RA2E, WA3E, RD1E, RD2E, ExtImmE, BubbleCnt
  );

  modport slave (
    input  StallE, FlushE, ValidD,
    input  RegWriteD, MemWriteD, MemtoRegD, BranchD, ALUSrcD,
    input  ALUControlD, FlagWriteD, CondD, FlagsD,
    input  RA1D, RA2D, WA3D, RD1D, RD2D, ExtImmD,
    output ValidE, RegWriteE, MemWriteE, MemtoRegE, BranchE, ALUSrcE,
    output ALUControlE, FlagWriteE, CondE, FlagsE,
    output RA1E, RA2E, WA3E, RD1E, RD2E, ExtImmE, BubbleCnt
  );

endinterface

// File: rtl/flopenrc.sv
// Flop with async active-low reset, enable and synchronous clear; reset and
// clear both load CLR_VAL, and clear takes priority over enable.
module flopenrc #(
  parameter int                 WIDTH   = 8,
  parameter logic [WIDTH-1:0]   CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   q <= CLR_VAL;
    else if (clr) q <= CLR_VAL;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/id_ex_reg.sv
// Decode->Execute pipeline register with stall, flush, valid qualification
// and a saturating count of bubbles entering the E stage.
module id_ex_reg
  import core_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic       clk,
  input  logic       reset,
  id_ex_reg_if.slave bus
);

  localparam int CTRLW = $bits(ctrl_t);
  localparam int OPW   = 3 * WIDTH;

  ctrl_t            ctrl_d, ctrl_q;
  logic [7:0]       cond_q;
  logic [3*REGW-1:0] addr_q;
  logic [OPW-1:0]   opnd_q;
  logic [CNTW-1:0]  bubble_cnt;
  logic             load_en;
  logic             bubble;

  assign load_en = ~bus.StallE;

  // A non-valid slot keeps its fields but can never write registers, memory,
  // flags or redirect the PC.
  always_comb begin
    ctrl_d            = '0;
    ctrl_d.valid      = bus.ValidD;
    ctrl_d.reg_write  = bus.RegWriteD & bus.ValidD;
    ctrl_d.mem_write  = bus.MemWriteD & bus.ValidD;
    ctrl_d.memto_reg  = bus.MemtoRegD;
    ctrl_d.branch     = bus.BranchD & bus.ValidD;
    ctrl_d.alu_src    = bus.ALUSrcD;
    ctrl_d.alu_ctrl   = bus.ALUControlD;
    ctrl_d.flag_write = bus.FlagWriteD & {2{bus.ValidD}};
  end

  flopenrc #(.WIDTH(CTRLW), .CLR_VAL('0)) u_ctrl (
    .clk(clk), .reset(reset), .en(load_en), .clr(bus.FlushE),
    .d(ctrl_d), .q(ctrl_q)
  );

  // Bubbles carry CondE=AL so the condition unit sees a harmless slot.
  flopenrc #(.WIDTH(8), .CLR_VAL({COND_AL, 4'b0000})) u_cond (
    .clk(clk), .reset(reset), .en(load_en), .clr(bus.FlushE),
    .d({bus.CondD, bus.FlagsD}), .q(cond_q)
  );

  flopenrc #(.WIDTH(3*REGW), .CLR_VAL('0)) u_addr (
    .clk(clk), .reset(reset), .en(load_en), .clr(bus.FlushE),
    .d({bus.RA1D, bus.RA2D, bus.WA3D}), .q(addr_q)
  );

  flopenrc #(.WIDTH(OPW), .CLR_VAL('0)) u_opnd (
    .clk(clk), .reset(reset), .en(load_en), .clr(bus.FlushE),
    .d({bus.RD1D, bus.RD2D, bus.ExtImmD}), .q(opnd_q)
  );

  // E ends up non-valid after a flush or after loading a non-valid slot.
  assign bubble = bus.FlushE | (~bus.StallE & ~bus.ValidD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      bubble_cnt <= '0;
    else if (bubble && (bubble_cnt != {CNTW{1'b1}}))
      bubble_cnt <= bubble_cnt + 1'b1;
  end

  assign bus.ValidE      = ctrl_q.valid;
  assign bus.RegWriteE   = ctrl_q.reg_write;
  assign bus.MemWriteE   = ctrl_q.mem_write;
  assign bus.MemtoRegE   = ctrl_q.memto_reg;
  assign bus.BranchE     = ctrl_q.branch;
  assign bus.ALUSrcE     = ctrl_q.alu_src;
  assign bus.ALUControlE = ctrl_q.alu_ctrl;
  assign bus.FlagWriteE  = ctrl_q.flag_write;
  assign bus.CondE       = cond_q[7:4];
  assign bus.FlagsE      = cond_q[3:0];
  assign bus.RA1E        = addr_q[3*REGW-1:2*REGW];
  assign bus.RA2E        = addr_q[2*REGW-1:REGW];
  assign bus.WA3E        = addr_q[REGW-1:0];
  assign bus.RD1E        = opnd_q[OPW-1:2*WIDTH];
  assign bus.RD2E        = opnd_q[2*WIDTH-1:WIDTH];
  assign bus.ExtImmE     = opnd_q[WIDTH-1:0];
  assign bus.BubbleCnt   = bubble_cnt;

endmodule
